// File: rtl/frame_writer.sv
// Raster-order pixel stream to SPRAM frame-buffer writer.
// Shares SPRAM with the vga reader and never writes while spram_rd_sig is high.
module frame_writer #(
  parameter int          W          = 5,
  parameter int          H          = 4,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          ADDR_W     = 16,
  parameter int          DATA_W     = 16,
  parameter logic [7:0]  LOAD_STATE = 8'h02
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        state,
  input  logic              spram_rd_sig,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [11:0]       x_cnt,
  output logic [11:0]       y_cnt,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [ADDR_W-1:0] idx_q;
  logic              pend_q;
  logic              pend_last_q;
  logic              load_ok;
  logic              xfer;
  logic              at_last;

  assign load_ok = (state == LOAD_STATE);
  assign xfer    = s_valid && s_ready;
  // A sof pixel always lands at (0,0), so it can never finish a frame.
  assign at_last = !s_sof && (x_cnt == 12'(W - 1)) && (y_cnt == 12'(H - 1));

  // A registered write that meets a vga read cycle waits until the RAM is free.
  assign wr_en      = pend_q && !spram_rd_sig;
  assign frame_done = wr_en && pend_last_q;
  assign busy       = (fsm_q == LOAD);

  always_comb begin
    fsm_d   = fsm_q;
    s_ready = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (load_ok) fsm_d = LOAD;
      end
      LOAD: begin
        s_ready = !spram_rd_sig;
        if (!load_ok)             fsm_d = IDLE;
        else if (xfer && at_last) fsm_d = DONE;
      end
      DONE: begin
        if (!load_ok) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      idx_q       <= '0;
    end else begin
      fsm_q <= fsm_d;

      if (wr_en) pend_q <= 1'b0;
      if (xfer) begin
        pend_q      <= 1'b1;
        pend_last_q <= at_last && load_ok;
        wr_data     <= s_data;
        wr_addr     <= ADDR_W'(BASE_ADDR) + (s_sof ? '0 : idx_q);
      end

      // Counters only live inside LOAD; leaving LOAD for any reason clears them.
      if (fsm_d != LOAD) begin
        x_cnt <= '0;
        y_cnt <= '0;
        idx_q <= '0;
      end else if (fsm_q == LOAD && xfer) begin
        if (s_sof) begin
          x_cnt <= 12'd1;
          y_cnt <= '0;
          idx_q <= ADDR_W'(1);
        end else begin
          if (x_cnt == 12'(W - 1)) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 12'd1;
          end else begin
            x_cnt <= x_cnt + 12'd1;
          end
          idx_q <= idx_q + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: directed frames plus randomized traffic
// compared every cycle against a pixel-index based reference model.
module tb_frame_writer;

  localparam int         W  = 5;
  localparam int         H  = 4;
  localparam int         N  = W * H;
  localparam logic [7:0] LS = 8'h02;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  state = 8'h00;
  logic        spram_rd_sig = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;

  logic        s_ready, wr_en, busy, frame_done;
  logic [15:0] wr_addr, wr_data;
  logic [11:0] x_cnt, y_cnt;

  logic        s_ready_b, wr_en_b, busy_b, frame_done_b;
  logic [15:0] wr_addr_b, wr_data_b;
  logic [11:0] x_cnt_b, y_cnt_b;

  int checks = 0;
  int errors = 0;
  int rd_mode = 0;

  frame_writer #(.W(W), .H(H), .BASE_ADDR(0), .ADDR_W(16), .DATA_W(16), .LOAD_STATE(LS)) dut (
    .clk(clk), .rst(rst), .state(state), .spram_rd_sig(spram_rd_sig),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .busy(busy), .frame_done(frame_done)
  );

  frame_writer #(.W(W), .H(H), .BASE_ADDR(32'h100), .ADDR_W(16), .DATA_W(16), .LOAD_STATE(LS)) dut_b (
    .clk(clk), .rst(rst), .state(state), .spram_rd_sig(spram_rd_sig),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .x_cnt(x_cnt_b), .y_cnt(y_cnt_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=load 2=done, m_pos is the linear pixel slot expected next.
  int          m_mode = 0;
  int          m_pos = 0;
  bit          m_pend = 0;
  bit          m_last = 0;
  int          m_addr = 0;
  logic [15:0] m_data = 16'h0;
  bit          started = 0;

  always @(posedge clk) begin
    bit xfer;
    int slot;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_pend = 0; m_last = 0; started = 1;
    end else begin
      if (m_pend && !spram_rd_sig) m_pend = 0;
      xfer = (m_mode == 1) && !spram_rd_sig && s_valid;
      slot = s_sof ? 0 : m_pos;
      case (m_mode)
        0: if (state == LS) m_mode = 1;
        1: begin
          if (xfer) begin
            m_pend = 1; m_addr = slot; m_data = s_data;
            m_last = (slot == N - 1) && (state == LS);
            m_pos = slot + 1;
          end
          if (state != LS) begin
            m_mode = 0; m_pos = 0;
          end else if (xfer && slot == N - 1) begin
            m_mode = 2; m_pos = 0;
          end
        end
        default: if (state != LS) m_mode = 0;
      endcase
    end
  end

  int          log_addr[$];
  logic [15:0] log_data[$];
  int          done_cnt = 0;
  int          done_addr = -1;

  always @(negedge clk) begin
    bit e_wr;
    if (started) begin
      e_wr = m_pend && !spram_rd_sig;
      check("s_ready", s_ready, (m_mode == 1) && !spram_rd_sig);
      check("wr_en", wr_en, e_wr);
      check("frame_done", frame_done, e_wr && m_last);
      check("busy", busy, m_mode == 1);
      check("x_cnt", x_cnt, m_pos % W);
      check("y_cnt", y_cnt, m_pos / W);
      check("wr_en_b", wr_en_b, e_wr);
      if (e_wr) begin
        check("wr_addr", wr_addr, m_addr);
        check("wr_data", wr_data, m_data);
        check("wr_addr_b", wr_addr_b, m_addr + 32'h100);
      end
      if (wr_en) begin
        log_addr.push_back(int'(wr_addr));
        log_data.push_back(wr_data);
      end
      if (frame_done) begin
        done_cnt++;
        done_addr = int'(wr_addr);
      end
    end
  end

  initial begin : rd_drive
    int phase;
    phase = 0;
    forever begin
      @(posedge clk); #1;
      case (rd_mode)
        0: spram_rd_sig = 1'b0;
        1: begin
          phase++;
          if (phase >= 3) begin
            phase = 0;
            spram_rd_sig = ~spram_rd_sig;
          end
        end
        default: spram_rd_sig = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_pixel(input logic [15:0] d, input logic sof);
    bit took;
    took = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof;
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_sof = 1'b0;
    if (!took) begin
      checks++; errors++;
      $display("[TB] FAIL send_pixel: pixel %0h never accepted, expected acceptance", d);
    end
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); done_cnt = 0; done_addr = -1;
  endtask

  task automatic rearm();
    state = 8'h00; tick(); state = LS; tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_x"}, x_cnt, 0);
    check({tag, "_y"}, y_cnt, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
  endtask

  task automatic check_full_frame(input string tag, input int data_base);
    check({tag, "_count"}, log_addr.size(), N);
    for (int j = 0; j < N && j < log_addr.size(); j++) begin
      check({tag, "_addr"}, log_addr[j], j);
      check({tag, "_data"}, log_data[j], data_base + j);
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_addr"}, done_addr, N - 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    check_reset_values("reset");
    rst = 1'b0;

    // Full frame with back-to-back pixels
    state = LS; tick();
    check("busy_rise", busy, 1);
    clear_log();
    for (int i = 0; i < N; i++) begin
      send_pixel(16'(i), 1'b0);
      if (i == 4) begin
        check("wrap_x", x_cnt, 0);
        check("wrap_y", y_cnt, 1);
      end
    end
    repeat (2) tick();
    check_full_frame("full", 0);
    check("done_s_ready", s_ready, 0);

    // Holding LOAD_STATE after DONE must not accept another frame
    s_valid = 1'b1; s_data = 16'hBEEF;
    repeat (10) tick();
    s_valid = 1'b0;
    check("no_reload", log_addr.size(), N);

    // Read contention
    rearm(); clear_log();
    rd_mode = 1;
    for (int i = 0; i < N; i++) send_pixel(16'h1000 + 16'(i), 1'b0);
    rd_mode = 0;
    repeat (4) tick();
    check_full_frame("contend", 32'h1000);

    // Resync with sof after 7 pixels
    rearm(); clear_log();
    for (int i = 0; i < 7; i++) send_pixel(16'(i), 1'b0);
    send_pixel(16'hAAAA, 1'b1);
    for (int i = 0; i < N - 1; i++) send_pixel(16'h200 + 16'(i), 1'b0);
    repeat (3) tick();
    check("sof_count", log_addr.size(), 7 + N);
    if (log_addr.size() == 7 + N) begin
      check("sof_addr", log_addr[7], 0);
      check("sof_data", log_data[7], 16'hAAAA);
      check("sof_next", log_addr[8], 1);
      check("sof_last", log_addr[7 + N - 1], N - 1);
    end
    check("sof_done_cnt", done_cnt, 1);

    // Abort by leaving LOAD_STATE
    rearm(); clear_log();
    for (int i = 0; i < 10; i++) send_pixel(16'(i), 1'b0);
    state = 8'h03;
    repeat (3) tick();
    check("abort_busy", busy, 0);
    check("abort_x", x_cnt, 0);
    check("abort_count", log_addr.size(), 10);
    check("abort_done", done_cnt, 0);
    state = LS; tick(); clear_log();
    send_pixel(16'h55, 1'b0);
    send_pixel(16'h56, 1'b0);
    tick();
    check("fresh_addr0", log_addr.size() > 0 ? log_addr[0] : -1, 0);
    check("fresh_addr1", log_addr.size() > 1 ? log_addr[1] : -1, 1);

    // Reset mid-frame, then a full frame from address 0
    send_pixel(16'h57, 1'b0);
    rst = 1'b1; tick();
    check_reset_values("midrst");
    rst = 1'b0;
    tick(); clear_log();
    for (int i = 0; i < N; i++) send_pixel(16'(i), 1'b0);
    repeat (2) tick();
    check_full_frame("after_rst", 0);

    // Randomized traffic against the model
    rd_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      state   = ($urandom_range(0, 99) < 93) ? LS : (($urandom_range(0, 1) == 1) ? 8'h03 : 8'h00);
      s_valid = ($urandom_range(0, 3) != 0);
      s_sof   = ($urandom_range(0, 39) == 0);
      s_data  = 16'($urandom);
      rst     = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0; rd_mode = 0; state = 8'h00;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
